// File: rtl/cordic_lin_pkg.sv
// Shared types and sizing helpers for the linear-mode CORDIC unit.
package cordic_lin_pkg;

    typedef enum logic {
        DIV = 1'b0,
        MUL = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Micro-rotations per operation: shift index runs -ext .. frac.
    function automatic int n_iter(input int frac, input int ext);
        return frac + ext + 1;
    endfunction

    function automatic int acc_width(input int width, input int ext, input int guard);
        return width + ext + 1 + guard;
    endfunction

    // Signed width able to hold every shift index.
    function automatic int idx_width(input int frac, input int ext);
        return $clog2(frac + ext + 1) + 1;
    endfunction

endpackage

// File: rtl/cordic_lin_step.sv
// One combinational linear-mode micro-rotation for either DIV (vectoring)
// or MUL (rotation) on guard-extended accumulators.
module cordic_lin_step
    import cordic_lin_pkg::*;
#(
    parameter int AW    = 26,
    parameter int FRAC  = 16,
    parameter int GUARD = 3,
    parameter int IW    = 6
) (
    input  mode_t                mode,
    input  logic signed [IW-1:0] idx,
    input  logic signed [AW-1:0] x,
    input  logic signed [AW-1:0] y,
    input  logic signed [AW-1:0] z,
    output logic signed [AW-1:0] y_nxt,
    output logic signed [AW-1:0] z_nxt
);

    int                   sh;
    logic signed [AW-1:0] s;
    logic signed [AW-1:0] c;
    logic                 add_s;

    always_comb begin
        sh = int'(idx);
        // negative index means the divisor/multiplicand is scaled up
        s  = (sh < 0) ? (x <<< (-sh)) : (x >>> sh);
        c  = AW'(1) << (FRAC + GUARD - sh);
        if (mode == DIV)
            add_s = (y[AW-1] != x[AW-1]);
        else
            add_s = !z[AW-1];
        y_nxt = add_s ? (y + s) : (y - s);
        z_nxt = add_s ? (z - c) : (z + c);
    end

endmodule

// File: rtl/cordic_linear_unit.sv
// Iterative linear CORDIC: z + y/x (DIV) or y + x*z (MUL), one micro-rotation
// per clock, with valid/ready handshakes and a saturation/divide-by-zero flag.
module cordic_linear_unit
    import cordic_lin_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int FRAC  = 16,
    parameter int EXT   = 2,
    parameter int GUARD = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int N  = n_iter(FRAC, EXT);
    localparam int AW = acc_width(WIDTH, EXT, GUARD);
    localparam int IW = idx_width(FRAC, EXT);
    localparam int CW = $clog2(N + 1);

    localparam logic signed [AW-1:0] SAT_HI = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    state_t               state, state_nxt;
    mode_t                mode_q;
    logic                 skip_q, ovf_q, qneg_q;
    logic [CW-1:0]        cnt;
    logic signed [IW-1:0] idx;
    logic signed [AW-1:0] x_acc, y_acc, z_acc;
    logic signed [AW-1:0] y_nxt, z_nxt;

    logic [WIDTH:0]       ax, ay;
    logic                 x_zero, q_ovf;
    logic [WIDTH-1:0]     y_fin, z_fin;
    logic                 y_sat, z_sat, err_fin;

    function automatic logic signed [AW-1:0] ext_load(input logic [WIDTH-1:0] v);
        return {{(EXT + 1){v[WIDTH-1]}}, v, {GUARD{1'b0}}};
    endfunction

    function automatic logic [WIDTH:0] sat_conv(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] t;
        t = a >>> GUARD;
        if (t > SAT_HI) return {1'b1, SAT_HI[WIDTH-1:0]};
        if (t < SAT_LO) return {1'b1, SAT_LO[WIDTH-1:0]};
        return {1'b0, t[WIDTH-1:0]};
    endfunction

    // A quotient of magnitude >= 2^(EXT+1) cannot be reached by the
    // iterations; it is caught up front and reported as a saturated result.
    always_comb begin
        ax     = x_in[WIDTH-1] ? -{1'b1, x_in} : {1'b0, x_in};
        ay     = y_in[WIDTH-1] ? -{1'b1, y_in} : {1'b0, y_in};
        x_zero = (x_in == '0);
        q_ovf  = !x_zero && ({{(EXT + 1){1'b0}}, ay} >= {ax, {(EXT + 1){1'b0}}});
    end

    assign idx = IW'(int'(cnt) - EXT);

    cordic_lin_step #(
        .AW    (AW),
        .FRAC  (FRAC),
        .GUARD (GUARD),
        .IW    (IW)
    ) u_step (
        .mode  (mode_q),
        .idx   (idx),
        .x     (x_acc),
        .y     (y_acc),
        .z     (z_acc),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    always_comb begin
        {y_sat, y_fin} = sat_conv(y_acc);
        {z_sat, z_fin} = sat_conv(z_acc);
        err_fin        = y_sat | z_sat | skip_q;
        if (ovf_q) begin
            z_fin   = qneg_q ? SAT_LO[WIDTH-1:0] : SAT_HI[WIDTH-1:0];
            err_fin = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == CW'(N)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= DIV;
            skip_q <= 1'b0;
            ovf_q  <= 1'b0;
            qneg_q <= 1'b0;
            cnt    <= '0;
            x_acc  <= '0;
            y_acc  <= '0;
            z_acc  <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode_t'(mode_in);
                        skip_q <= !mode_in && x_zero;
                        ovf_q  <= !mode_in && q_ovf;
                        qneg_q <= x_in[WIDTH-1] ^ y_in[WIDTH-1];
                        cnt    <= '0;
                        x_acc  <= ext_load(x_in);
                        y_acc  <= ext_load(y_in);
                        z_acc  <= ext_load(z_in);
                    end
                end
                RUN: begin
                    // the extra cycle after the last step registers the converted result
                    if (cnt == CW'(N)) begin
                        x_out <= x_acc[GUARD +: WIDTH];
                        y_out <= y_fin;
                        z_out <= z_fin;
                        err   <= err_fin;
                    end else begin
                        if (!skip_q) begin
                            y_acc <= y_nxt;
                            z_acc <= z_nxt;
                        end
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cordic_linear_unit.md
# cordic_linear_unit

- Iterative, parametrised linear-mode CORDIC engine for the MLP datapath.
- Replaces the fixed 20-bit `Main` divide unit with a generalised block that:
  - computes either `z + y/x` (DIV, vectoring) or `y + x*z` (MUL, rotation);
  - runs one micro-rotation per clock;
  - adds a valid/ready handshake, extended input range and an error flag.
- Sits between the neuron accumulator and the activation/normalisation stage.

## Interface
Parameters:
- `WIDTH`, 20: word width; signed two's complement for all data ports.
- `FRAC`, 16: fractional bits. Default format is Q3.16, range [-8, 8).
- `EXT`, 2: range-extension iterations (negative shift indices).
  - Result magnitude must be below 2^(EXT+1).
- `GUARD`, 3: extra LSB guard bits in internal accumulators.

Ports:
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `mode_in`, in, 1: 0 = DIV, 1 = MUL. Sampled at input handshake.
- `x_in`, in, WIDTH: divisor (DIV) or multiplicand (MUL).
- `y_in`, in, WIDTH: dividend (DIV) or addend (MUL).
- `z_in`, in, WIDTH: addend (DIV) or multiplier (MUL).
- `in_valid`, in, 1: input operands valid.
- `in_ready`, out, 1: block can accept operands.
- `x_out`, out, WIDTH: x passed through unchanged.
- `y_out`, out, WIDTH: DIV gives the residual (≈0); MUL gives `y_in + x_in*z_in`.
- `z_out`, out, WIDTH: DIV gives `z_in + y_in/x_in`; MUL gives the residual (≈0).
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `err`, out, 1: divide-by-zero or saturation. Qualified by `out_valid`.

## Operation
- Number of iterations: N = FRAC + EXT + 1, with shift index i running from -EXT up to FRAC.
- Shifted term: s = x·2^-i. For negative i this is a left shift of x.
- Constant term: c = 2^-i in FRAC format.
- DIV step:
  - if sign(y) == sign(x) (y=0 counts as positive): y -= s, z += c;
  - otherwise: y += s, z -= c.
- MUL step:
  - if z ≥ 0: y += s, z -= c;
  - otherwise: y -= s, z += c.
- Accumulator width: WIDTH+EXT+1+GUARD bits.
  - Operands are sign-extended on load.
  - Guard bits are appended as zeros.
- Output conversion:
  - drop the guard bits by truncation;
  - saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1];
  - `err` = 1 if any output saturated.
- DIV with `x_in` = 0:
  - no iterations are applied;
  - outputs are `y_in`/`z_in` unchanged, `err` = 1;
  - latency is the same as a normal operation.
- States:
  - IDLE: `in_ready` = 1. On `in_valid`, load registers, clear the counter, go to RUN.
  - RUN: one step per cycle. After step N go to DONE.
  - DONE: `out_valid` = 1, outputs held stable. When `out_ready` = 1, go to IDLE.

## Timing
- Reset values: all outputs 0 except `in_ready` = 1. State is IDLE, counter is 0.
- Operand acceptance happens at the edge where `in_valid & in_ready` = 1; call it cycle 0.
- `out_valid` rises N+1 cycles after that edge. Defaults: N = 19, latency 20.
- `in_ready` is 0 from the edge after acceptance until the edge leaving DONE.
  - No back-to-back overlap: throughput is one result per N+2 cycles minimum.
- Outputs and `err` stay stable while `out_valid` = 1 and `out_ready` = 0.
- `rst` asserted in any state: next edge returns to IDLE, the operation is aborted and no output is produced.
- `in_valid` toggling during RUN or DONE is ignored.

## Structure
- Package `cordic_lin_pkg` holds:
  - `mode_t` enum (DIV, MUL);
  - `state_t` enum (IDLE, RUN, DONE);
  - localparam functions for N and accumulator width.
- Sub-module `cordic_lin_step`: combinational single micro-rotation.
  - Inputs: mode, shift index, x, y, z. Outputs: next y, z.
  - Top-level instantiates it once and muxes it into the registers.

## Test plan
- DIV: x = 0x24000 (2.25), y = 0x48000 (4.5), z = 0 → z_out within 2 LSB of 0x20000 (2.0), err = 0, `out_valid` at cycle 20.
- MUL: x = 0x18000 (1.5), y = 0x10000 (1.0), z = 0xE0000 (-2.0) → y_out within 2 LSB of 0xE0000 (-2.0), err = 0.
- DIV with x = 0, y = 0x10000 → z_out = z_in, y_out = 0x10000, err = 1, same latency.
- DIV with x = 0x01000, y = 0x70000 (quotient 112, beyond range) → z_out = 0x7FFFF, err = 1.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE → outputs stable, `in_ready` = 0; release → `in_ready` = 1 next cycle.
- Assert `rst` at cycle 7 of RUN → next cycle IDLE, `out_valid` stays 0; a new operation then completes correctly.
